conv_loop_controller: RTL and testbench

CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

---
 rtl/conv_ctrl_pkg.sv | 15 +
 rtl/loop_counter.sv | 26 ++
 rtl/conv_loop_controller.sv | 96 +++++++++
 tb/tb_conv_loop_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and width helpers for the convolution loop controller.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } ctrl_state_t;

    // Counter width for an extent; a single-value loop still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/loop_counter.sv
// One loop level: counts enabled steps and raises wrap on the step that returns it to 0.
module loop_counter
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned MAX = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   en,
    output logic [cnt_w(MAX)-1:0]  count,
    output logic                   wrap
);

    localparam int unsigned      W    = cnt_w(MAX);
    localparam logic [W-1:0]     LAST = W'(MAX - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            count <= '0;
        else if (en)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/conv_loop_controller.sv
// Sequences the y/x/ch_out/ky/kx/ch_in convolution loops over paired activation/weight beats.
module conv_loop_controller
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned FEATURE_MAP_WIDTH  = 128,
    parameter int unsigned FEATURE_MAP_HEIGHT = 128,
    parameter int unsigned INPUT_NB_CHANNELS  = 2,
    parameter int unsigned OUTPUT_NB_CHANNELS = 16,
    parameter int unsigned KERNEL_SIZE        = 3
) (
    input  logic                                   clk,
    input  logic                                   arst,
    input  logic                                   start,
    output logic                                   running,
    input  logic                                   a_valid,
    input  logic                                   b_valid,
    input  logic                                   a_zero_flag,
    input  logic                                   b_zero_flag,
    output logic                                   a_ready,
    output logic                                   b_ready,
    output logic                                   acc_clear,
    output logic                                   mac_en,
    output logic                                   output_valid,
    output logic [cnt_w(FEATURE_MAP_WIDTH)-1:0]    output_x,
    output logic [cnt_w(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    output logic [cnt_w(OUTPUT_NB_CHANNELS)-1:0]   output_ch
);

    ctrl_state_t state, state_next;
    logic        fire;

    logic [cnt_w(INPUT_NB_CHANNELS)-1:0]  ch_in;
    logic [cnt_w(KERNEL_SIZE)-1:0]        kx, ky;
    logic [cnt_w(OUTPUT_NB_CHANNELS)-1:0] ch_out;
    logic [cnt_w(FEATURE_MAP_WIDTH)-1:0]  x;
    logic [cnt_w(FEATURE_MAP_HEIGHT)-1:0] y;
    logic wrap_ch_in, wrap_kx, wrap_ky, wrap_ch_out, wrap_x, wrap_y;

    // Innermost first; each level steps only on the wrap of the one inside it.
    loop_counter #(.MAX(INPUT_NB_CHANNELS)) u_ch_in (
        .clk(clk), .arst(arst), .en(fire), .count(ch_in), .wrap(wrap_ch_in));
    loop_counter #(.MAX(KERNEL_SIZE)) u_kx (
        .clk(clk), .arst(arst), .en(wrap_ch_in), .count(kx), .wrap(wrap_kx));
    loop_counter #(.MAX(KERNEL_SIZE)) u_ky (
        .clk(clk), .arst(arst), .en(wrap_kx), .count(ky), .wrap(wrap_ky));
    loop_counter #(.MAX(OUTPUT_NB_CHANNELS)) u_ch_out (
        .clk(clk), .arst(arst), .en(wrap_ky), .count(ch_out), .wrap(wrap_ch_out));
    loop_counter #(.MAX(FEATURE_MAP_WIDTH)) u_x (
        .clk(clk), .arst(arst), .en(wrap_ch_out), .count(x), .wrap(wrap_x));
    loop_counter #(.MAX(FEATURE_MAP_HEIGHT)) u_y (
        .clk(clk), .arst(arst), .en(wrap_x), .count(y), .wrap(wrap_y));

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)  state_next = RUN;
            RUN:     if (wrap_y) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running   = (state != IDLE);
        fire      = (state == RUN) && a_valid && b_valid;
        a_ready   = fire;
        b_ready   = fire;
        acc_clear = fire && (ch_in == '0) && (kx == '0) && (ky == '0);
        mac_en    = fire && !a_zero_flag && !b_zero_flag;
    end

    // wrap_ky marks the fire carrying the last term of the current output.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            output_valid <= 1'b0;
            output_x     <= '0;
            output_y     <= '0;
            output_ch    <= '0;
        end else begin
            output_valid <= wrap_ky;
            if (wrap_ky) begin
                output_x  <= x;
                output_y  <= y;
                output_ch <= ch_out;
            end
        end
    end

endmodule

// File: tb/tb_conv_loop_controller.sv
// Checks conv_loop_controller against an index-arithmetic model of the loop nest.
module tb_conv_loop_controller;

    localparam int W     = 2;
    localparam int H     = 2;
    localparam int CIN   = 2;
    localparam int COUT  = 2;
    localparam int K     = 3;
    localparam int PER   = K * K * CIN;
    localparam int TOTAL = W * H * COUT * PER;

    logic clk = 1'b0;
    logic arst, start, av, bv, az, bz;
    logic running, a_ready, b_ready, acc_clear, mac_en, output_valid;
    logic [0:0] output_x, output_y, output_ch;

    logic start1, av1, bv1;
    logic running1, a_ready1, b_ready1, acc_clear1, mac_en1, output_valid1;
    logic [0:0] output_x1, output_y1, output_ch1;

    always #5 clk = ~clk;

    conv_loop_controller #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CIN),
        .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .running(running),
        .a_valid(av), .b_valid(bv), .a_zero_flag(az), .b_zero_flag(bz),
        .a_ready(a_ready), .b_ready(b_ready), .acc_clear(acc_clear), .mac_en(mac_en),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch)
    );

    conv_loop_controller #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(1),
        .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(1)
    ) dut_k1 (
        .clk(clk), .arst(arst), .start(start1), .running(running1),
        .a_valid(av1), .b_valid(bv1), .a_zero_flag(1'b0), .b_zero_flag(1'b0),
        .a_ready(a_ready1), .b_ready(b_ready1), .acc_clear(acc_clear1), .mac_en(mac_en1),
        .output_valid(output_valid1), .output_x(output_x1), .output_y(output_y1),
        .output_ch(output_ch1)
    );

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 running beats, 2 draining; m_n is the beat index within the run.
    int m_mode, m_n, m_ox, m_oy, m_och;
    bit m_ov;

    int obs_fire, obs_mac, obs_clr, obs_ov, first_ov_fires;
    int obs_c[$];

    typedef struct {
        bit av, bv, az, bz;
        bit rdy, mac, clr;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_ov = 0; m_ox = 0; m_oy = 0; m_och = 0;
    endtask

    task automatic clear_obs();
        obs_fire = 0; obs_mac = 0; obs_clr = 0; obs_ov = 0; first_ov_fires = -1;
        obs_c.delete();
    endtask

    task automatic model_check();
        bit exp_fire;
        int o;
        exp_fire = (m_mode == 1) && av && bv;
        chk("running", int'(running), int'(m_mode != 0));
        chk("a_ready", int'(a_ready), int'(exp_fire));
        chk("b_ready", int'(b_ready), int'(exp_fire));
        chk("acc_clear", int'(acc_clear), int'(exp_fire && (m_n % PER) == 0));
        chk("mac_en", int'(mac_en), int'(exp_fire && !az && !bz));
        chk("output_valid", int'(output_valid), int'(m_ov));
        chk("output_x", int'(output_x), m_ox);
        chk("output_y", int'(output_y), m_oy);
        chk("output_ch", int'(output_ch), m_och);
        if (output_valid) begin
            if (obs_ov == 0) first_ov_fires = obs_fire;
            obs_ov++;
            obs_c.push_back(int'(output_y) * 100 + int'(output_x) * 10 + int'(output_ch));
        end
        if (a_ready) obs_fire++;
        if (mac_en) obs_mac++;
        if (acc_clear) obs_clr++;
        if (arst) begin
            model_reset();
        end else begin
            m_ov = 0;
            case (m_mode)
                0: if (start) m_mode = 1;
                2: m_mode = 0;
                default: if (exp_fire) begin
                    if ((m_n + 1) % PER == 0) begin
                        o = m_n / PER;
                        m_ov = 1;
                        m_och = o % COUT;
                        m_ox = (o / COUT) % W;
                        m_oy = o / (COUT * W);
                    end
                    m_n++;
                    if (m_n == TOTAL) begin
                        m_n = 0;
                        m_mode = 2;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input string name, output int cyc);
        cyc = 0;
        while (running && cyc < 2000) begin
            step();
            cyc++;
        end
        if (cyc >= 2000) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int cyc;
        int k;
        tbl[0] = '{1, 1, 0, 0, 1, 1, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 0, 1, 0, 0};
        tbl[4] = '{1, 1, 0, 1, 1, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[6] = '{1, 1, 0, 0, 1, 1, 0};

        arst = 1'b1; start = 1'b0; av = 1'b0; bv = 1'b0; az = 1'b0; bz = 1'b0;
        start1 = 1'b0; av1 = 1'b0; bv1 = 1'b0;
        model_reset();
        clear_obs();
        step();
        step();
        arst = 1'b0;
        step();

        // Full run with both streams always valid.
        clear_obs();
        av = 1'b1; bv = 1'b1;
        pulse_start();
        run_to_idle("full_run", cyc);
        chk("run_length", cyc + 1, 146);
        chk("full_fires", obs_fire, TOTAL);
        chk("full_outputs", obs_ov, 8);
        chk("first_out_fires", first_ov_fires, PER);
        if (obs_c.size() == 8) begin
            chk("first_coord", obs_c[0], 0);
            chk("second_coord", obs_c[1], 1);
            chk("last_coord", obs_c[7], 111);
        end else begin
            chk("coord_count", obs_c.size(), 8);
        end

        // Vector table at the start of a run, then a one-sided stall.
        clear_obs();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            av = tbl[i].av; bv = tbl[i].bv; az = tbl[i].az; bz = tbl[i].bz;
            @(negedge clk);
            chk($sformatf("tbl%0d_a_ready", i), int'(a_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_b_ready", i), int'(b_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_mac_en", i), int'(mac_en), int'(tbl[i].mac));
            chk($sformatf("tbl%0d_acc_clear", i), int'(acc_clear), int'(tbl[i].clr));
            model_check();
            @(posedge clk);
            #1;
        end
        az = 1'b0; bz = 1'b0;
        av = 1'b1; bv = 1'b0;
        k = obs_fire;
        for (int i = 0; i < 10; i++) step();
        chk("stall_fires", obs_fire, k);
        bv = 1'b1;
        run_to_idle("stall_run", cyc);
        chk("stall_outputs", obs_ov, 8);
        chk("stall_fires_total", obs_fire, TOTAL);

        // Zero flag on every odd beat.
        clear_obs();
        pulse_start();
        while (running && obs_fire < 1000) begin
            az = obs_fire[0];
            step();
        end
        az = 1'b0;
        chk("zero_mac", obs_mac, TOTAL / 2);
        chk("zero_clear", obs_clr, 8);
        chk("zero_outputs", obs_ov, 8);

        // Reset after beat 50, then a fresh run.
        clear_obs();
        pulse_start();
        k = 0;
        while (obs_fire < 50 && k < 500) begin
            step();
            k++;
        end
        chk("pre_reset_fires", obs_fire, 50);
        k = obs_ov;
        arst = 1'b1;
        model_reset();
        step(); step(); step();
        chk("reset_no_output", obs_ov, k);
        arst = 1'b0;
        step();
        clear_obs();
        pulse_start();
        k = 0;
        while (obs_ov == 0 && k < 200) begin
            step();
            k++;
        end
        chk("restart_first_fires", first_ov_fires, PER);
        chk("restart_first_coord", (obs_c.size() > 0) ? obs_c[0] : -1, 0);
        run_to_idle("restart_run", cyc);
        chk("restart_outputs", obs_ov, 8);

        // Start pulses in RUN and in the FLUSH cycle are ignored.
        clear_obs();
        pulse_start();
        k = 0;
        while (running && k < 2000) begin
            start = (k == 30) || (m_mode == 2);
            step();
            k++;
        end
        start = 1'b0;
        step();
        chk("ignored_start_outputs", obs_ov, 8);
        chk("idle_after_flush", int'(running), 0);
        clear_obs();
        pulse_start();
        run_to_idle("second_start", cyc);
        chk("second_start_outputs", obs_ov, 8);

        // Randomised beats, zero flags and spurious starts.
        for (int r = 0; r < 3; r++) begin
            clear_obs();
            pulse_start();
            k = 0;
            while (running && k < 3000) begin
                av = ($urandom_range(0, 3) != 0);
                bv = ($urandom_range(0, 3) != 0);
                az = ($urandom_range(0, 3) == 0);
                bz = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 19) == 0);
                step();
                k++;
            end
            start = 1'b0;
            chk($sformatf("rand%0d_fires", r), obs_fire, TOTAL);
            chk($sformatf("rand%0d_outputs", r), obs_ov, 8);
        end
        av = 1'b1; bv = 1'b1; az = 1'b0; bz = 1'b0;
        step();

        // K=1, CIN=1: every beat is both first and last term of its output.
        av1 = 1'b1; bv1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int o;
            @(negedge clk);
            o = i - 1;
            chk("k1_running", int'(running1), int'(i <= 8));
            chk("k1_a_ready", int'(a_ready1), int'(i < 8));
            chk("k1_b_ready", int'(b_ready1), int'(i < 8));
            chk("k1_acc_clear", int'(acc_clear1), int'(i < 8));
            chk("k1_mac_en", int'(mac_en1), int'(i < 8));
            chk("k1_output_valid", int'(output_valid1), int'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8) begin
                chk("k1_output_ch", int'(output_ch1), o % COUT);
                chk("k1_output_x", int'(output_x1), (o / COUT) % W);
                chk("k1_output_y", int'(output_y1), o / (COUT * W));
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
